add16_share_arb: RTL

Two-requester arbiter and sequencer that time-shares one 16-bit adder datapath between the fetch path (PC increment) and the execute path (branch target / ALU add). Each requester presents operands through a valid/ready handshake. The arbiter grants round-robin, drives a single combinational adder core, and registers the result into a one-deep output stage with back-pressure. It sits between the datapath's adder users and the shared adder instance.

---
 rtl/add16_pkg.sv | 20 ++
 rtl/add16_core.sv | 29 ++
 rtl/add16_share_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/add16_pkg.sv
// Shared definitions for the time-shared 16-bit adder: default width,
// sequencer state encoding and requester indices.
package add16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_EXEC  = 1'b1;

    // Round-robin pick under contention: the requester not granted last wins.
    function automatic logic rr_pick(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/add16_core.sv
// Purely combinational add/subtract core; the single shared adder instance.
// Subtraction is a + ~b + 1, so cout=1 means "no borrow".
module add16_core
    import add16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_ext;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_ext   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

    assign o_sum  = w_ext[WIDTH-1:0];
    assign o_cout = w_ext[WIDTH];

    // Signed overflow: operands agree in sign but the result does not.
    assign o_ovf  = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_ext[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/add16_share_arb.sv
// Round-robin arbiter time-sharing one adder between fetch (0) and execute (1),
// with a one-deep registered result stage that honours back-pressure.
module add16_share_arb
    import add16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_req_valid,
    input  logic [WIDTH-1:0] i_req_a0,
    input  logic [WIDTH-1:0] i_req_b0,
    input  logic [WIDTH-1:0] i_req_a1,
    input  logic [WIDTH-1:0] i_req_b1,
    input  logic [1:0]       i_req_sub,
    output logic [1:0]       o_req_ready,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_sum,
    output logic             o_rsp_cout,
    output logic             o_rsp_ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             w_can_accept;
    logic             w_grant_valid;
    logic             w_grant_idx;
    logic             w_transfer;
    logic [1:0]       w_req_ready;

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_op_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;
    logic             r_rsp_ovf;
    logic             r_rsp_id;

    // The slot is free when empty or when the held result leaves this cycle.
    assign w_can_accept = (r_state == EMPTY) || i_rsp_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = r_last_grant;
        w_req_ready   = 2'b00;
        case (i_req_valid)
            2'b01: begin
                w_grant_valid = 1'b1;
                w_grant_idx   = REQ_FETCH;
            end
            2'b10: begin
                w_grant_valid = 1'b1;
                w_grant_idx   = REQ_EXEC;
            end
            2'b11: begin
                w_grant_valid = 1'b1;
                w_grant_idx   = rr_pick(r_last_grant);
            end
            default: begin
                w_grant_valid = 1'b0;
                w_grant_idx   = r_last_grant;
            end
        endcase
        if (w_can_accept && w_grant_valid) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_transfer  = w_can_accept && w_grant_valid;
    assign o_req_ready = w_req_ready;

    assign w_op_a   = w_grant_idx ? i_req_a1 : i_req_a0;
    assign w_op_b   = w_grant_idx ? i_req_b1 : i_req_b0;
    assign w_op_sub = i_req_sub[w_grant_idx];

    add16_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_sub  (w_op_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_transfer) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (i_rsp_ready && !w_transfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset to 1 so that fetch wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_transfer) begin
            r_last_grant <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else if (w_transfer) begin
            r_rsp_sum  <= w_sum;
            r_rsp_cout <= w_cout;
            r_rsp_ovf  <= w_ovf;
            r_rsp_id   <= w_grant_idx;
        end
    end

    assign o_rsp_valid = (r_state == FULL);
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_cout  = r_rsp_cout;
    assign o_rsp_ovf   = r_rsp_ovf;
    assign o_rsp_id    = r_rsp_id;

endmodule
